ibis_tmds_channel_encoder: RTL
==============================

Name: ibis_tmds_channel_encoder

Overview:
One-lane HDMI-capable TMDS encoder: the successor to the DVI-only lane encoder, adding guard-band and TERC4 (data island) symbol modes, a per-lane channel parameter and a fixed two-stage pipeline for timing closure. One instance per lane (CHANNEL 0/1/2). Instances sit between the video/packet timing generator and the 10:1 serialiser. Output symbols use the same bit order as the existing serialiser path: bit 0 is transmitted first.

Parameters:
CHANNEL, 0, lane index 0..2; selects guard-band symbols and the island-guard behaviour.
BIAS_WIDTH, 5, signed running-disparity width; must be at least 5 (elaboration assertion).

Ports:
clock  in  1  system pixel clock; all state on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  clock enable; when 0 every register, including the bias, holds
mode  in  3  symbol mode, ibis_tmds_pkg::mode_t
data  in  8  video byte (VIDEO mode)
control  in  2  {c1,c0} (CONTROL mode; HSYNC/VSYNC in ISLAND_GUARD mode on CHANNEL 0)
terc4  in  4  data-island nibble (TERC4 mode)
out_parallel  out  10  encoded symbol
debug_bias  out  BIAS_WIDTH  current running disparity (signed)

Behaviour:
- One clock domain, clock; reset is synchronous and active-high. Reset has priority over enable.
- Reset values:
  - out_parallel = 10'b1101010100 (control 00).
  - debug_bias = 0.
  - Stage-1 registers load mode=CONTROL, control=00.
- Modes: 0 CONTROL, 1 VIDEO, 2 VIDEO_GUARD, 3 ISLAND_GUARD, 4 TERC4. Codes 5..7 are treated as CONTROL.
- Latency: 2 enabled cycles from input to out_parallel. enable=0 freezes both stages, so nothing is lost or duplicated.
- Stage 1 (registered):
  - Mode, control and terc4 are registered.
  - For VIDEO: ones=popcount(data); use_xnor=(ones>4)|(ones==4 & ~data[0]).
  - q_m[0]=data[0]; q_m[i]=q_m[i-1] XOR/XNOR data[i]; q_m[8]=~use_xnor.
  - balance = 2*popcount(q_m[7:0]) - 8, registered as signed BIAS_WIDTH.
- Stage 2, VIDEO (r=bias, b=balance):
  - If r==0 or b==0: out={~q8, q8, q8 ? q_m[7:0] : ~q_m[7:0]}; r += q8 ? b : -b.
  - Else if sign(r)==sign(b): out={1, q8, ~q_m[7:0]}; r = r + 2*q8 - b.
  - Else: out={0, q8, q_m[7:0]}; r = r - 2*~q8 + b.
  - Arithmetic is signed BIAS_WIDTH, 2's-complement. The magnitude stays ≤10, so it never wraps at width ≥5.
- Stage 2, non-VIDEO modes (bias forced to 0 in all of them):
  - CONTROL: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - VIDEO_GUARD: CHANNEL 0 and 2 → 1011001100; CHANNEL 1 → 0100110011.
  - ISLAND_GUARD: CHANNEL 1 and 2 → 0100110011; CHANNEL 0 → TERC4({2'b11, control}).
  - TERC4: out = HDMI 1.4 TERC4 table[terc4].
- Mode changes take effect on the symbol boundary with no extra latency. Entering VIDEO starts with bias 0, because any preceding non-video symbol has cleared it.
- Reset mid-stream: both stages flush. The first symbol after reset deasserts is the control-00 symbol until new stage-1 data arrives (2 cycles).

Decomposition:
- Package ibis_tmds_pkg holds:
  - mode_t enum.
  - Control-symbol constants CTRL_SYM[4].
  - Guard constants GUARD_0B4C=1011001100 and GUARD_4CB3=0100110011.
  - TERC4 table constant TERC4_SYM[16] (0:1010011100, 1:1001100011, 2:1011100100, 3:1011100010, 4:0101110001, 5:0100011110, 6:0110001110, 7:0100111100, 8:1011001100, 9:0100111001, 10:0110011100, 11:1011000110, 12:1010001110, 13:1001110001, 14:0101100011, 15:1011000011).
- Sub-module ibis_tmds_qm: combinational q_m and balance generator, instantiated in stage 1 and unit-testable on its own.

Test Plan:
- Reset: hold reset 3 cycles with random inputs → out_parallel=1101010100 and debug_bias=0 every cycle, and for 2 cycles after release when mode=CONTROL, control=00.
- VIDEO 0x00 steady stream → outputs 0100000000, 1111111111, 0100000000, 1111111111, ... with bias sequence -8, 2, -6, 4, -4, 6, -2, 8, 0 (then the sequence repeats).
- Mode sweep on CHANNEL=0: VIDEO_GUARD → 1011001100; ISLAND_GUARD with control=01 → TERC4[13]=1001110001; TERC4 with terc4=8 → 1011001100; bias=0 after each. The same sweep on CHANNEL=1 gives ISLAND_GUARD → 0100110011.
- Enable stall: after a VIDEO burst, drop enable 5 cycles → out_parallel and debug_bias frozen; on resume, the next two symbols are exactly the ones that were in flight.
- Reset mid-video with bias≠0 → next cycle bias=0, out=1101010100; resumed VIDEO 0x00 restarts at 0100000000, bias -8.
- Exhaustive random VIDEO bytes against a behavioural reference model → symbol-exact match; decoded bytes round-trip; |bias| ≤ 10 always.

Source files
------------

// File: rtl/ibis_tmds_pkg.sv
// Shared types and symbol tables for the HDMI TMDS lane encoder.
// All symbols are out_parallel[9:0]; bit 0 leaves the serialiser first.
package ibis_tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CONTROL      = 3'd0,
    MODE_VIDEO        = 3'd1,
    MODE_VIDEO_GUARD  = 3'd2,
    MODE_ISLAND_GUARD = 3'd3,
    MODE_TERC4        = 3'd4
  } mode_t;

  localparam logic [9:0] CTRL_SYM [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] GUARD_0B4C = 10'b1011001100;
  localparam logic [9:0] GUARD_4CB3 = 10'b0100110011;

  localparam logic [9:0] TERC4_SYM [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Stage-1 register contents (balance lives beside it, its width is a parameter)
  typedef struct packed {
    mode_t      mode;
    logic [1:0] control;
    logic [3:0] terc4;
    logic [8:0] q_m;
  } s1_t;

  // Unassigned mode codes fall back to control symbols
  function automatic mode_t decode_mode(input logic [2:0] code);
    mode_t m;
    case (code)
      3'd1:    m = MODE_VIDEO;
      3'd2:    m = MODE_VIDEO_GUARD;
      3'd3:    m = MODE_ISLAND_GUARD;
      3'd4:    m = MODE_TERC4;
      default: m = MODE_CONTROL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ibis_tmds_channel_encoder_qm.sv
// Transition-minimising stage: byte -> q_m[8:0] plus signed balance of q_m[7:0].
module ibis_tmds_qm
  import ibis_tmds_pkg::*;
#(
  parameter int BIAS_WIDTH = 5
) (
  input  logic [7:0]            data,
  output logic [8:0]            q_m,
  output logic [BIAS_WIDTH-1:0] balance
);

  logic [3:0] ones_d;
  logic [3:0] ones_q;
  logic       use_xnor;

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < 8; i++) ones_d = ones_d + 4'(data[i]);
    use_xnor = (ones_d > 4'd4) || ((ones_d == 4'd4) && !data[0]);

    q_m    = '0;
    q_m[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8] = ~use_xnor;

    ones_q = '0;
    for (int i = 0; i < 8; i++) ones_q = ones_q + 4'(q_m[i]);
    // ones minus zeros = 2*ones - 8, range -8..8
    balance = BIAS_WIDTH'({ones_q, 1'b0}) - BIAS_WIDTH'(8);
  end

endmodule

// File: rtl/ibis_tmds_channel_encoder.sv
// One TMDS lane: video / control / guard-band / TERC4 symbols, two-stage pipeline
// with running-disparity tracking for video.
module ibis_tmds_channel_encoder
  import ibis_tmds_pkg::*;
#(
  parameter int CHANNEL    = 0,
  parameter int BIAS_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            mode,
  input  logic [7:0]            data,
  input  logic [1:0]            control,
  input  logic [3:0]            terc4,
  output logic [9:0]            out_parallel,
  output logic [BIAS_WIDTH-1:0] debug_bias
);

  if (BIAS_WIDTH < 5) begin : g_bias_width_check
    $error("ibis_tmds_channel_encoder: BIAS_WIDTH must be at least 5");
  end

  localparam logic signed [BIAS_WIDTH-1:0] TWO = BIAS_WIDTH'(2);

  // ---------------- stage 1 ----------------
  logic [8:0]            qm;
  logic [BIAS_WIDTH-1:0] qm_bal;
  s1_t                   s1;
  logic signed [BIAS_WIDTH-1:0] s1_bal;

  ibis_tmds_qm #(.BIAS_WIDTH(BIAS_WIDTH)) u_qm (
    .data    (data),
    .q_m     (qm),
    .balance (qm_bal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '{mode: MODE_CONTROL, default: '0};
      s1_bal <= '0;
    end else if (enable) begin
      s1     <= '{mode: decode_mode(mode), control: control, terc4: terc4, q_m: qm};
      s1_bal <= $signed(qm_bal);
    end
  end

  // ---------------- stage 2 ----------------
  logic signed [BIAS_WIDTH-1:0] bias_q;
  logic signed [BIAS_WIDTH-1:0] bias_nxt;
  logic signed [BIAS_WIDTH-1:0] q8_x2;
  logic signed [BIAS_WIDTH-1:0] nq8_x2;
  logic [9:0]                   sym_nxt;
  logic [9:0]                   sym_q;
  logic                         q8;

  assign q8     = s1.q_m[8];
  assign q8_x2  = q8 ? TWO : '0;
  assign nq8_x2 = q8 ? '0 : TWO;

  always_comb begin
    sym_nxt  = CTRL_SYM[s1.control];
    bias_nxt = '0;
    case (s1.mode)
      MODE_VIDEO: begin
        if ((bias_q == '0) || (s1_bal == '0)) begin
          sym_nxt  = {~q8, q8, q8 ? s1.q_m[7:0] : ~s1.q_m[7:0]};
          bias_nxt = q8 ? (bias_q + s1_bal) : (bias_q - s1_bal);
        end else if (bias_q[BIAS_WIDTH-1] == s1_bal[BIAS_WIDTH-1]) begin
          // same sign: invert to pull the disparity back toward zero
          sym_nxt  = {1'b1, q8, ~s1.q_m[7:0]};
          bias_nxt = bias_q + q8_x2 - s1_bal;
        end else begin
          sym_nxt  = {1'b0, q8, s1.q_m[7:0]};
          bias_nxt = bias_q - nq8_x2 + s1_bal;
        end
      end
      MODE_VIDEO_GUARD:
        sym_nxt = (CHANNEL == 1) ? GUARD_4CB3 : GUARD_0B4C;
      MODE_ISLAND_GUARD:
        // lane 0 carries HSYNC/VSYNC in the guard band as TERC4 codes 12..15
        sym_nxt = (CHANNEL == 0) ? TERC4_SYM[{2'b11, s1.control}] : GUARD_4CB3;
      MODE_TERC4:
        sym_nxt = TERC4_SYM[s1.terc4];
      default:
        sym_nxt = CTRL_SYM[s1.control];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sym_q  <= CTRL_SYM[0];
      bias_q <= '0;
    end else if (enable) begin
      sym_q  <= sym_nxt;
      bias_q <= bias_nxt;
    end
  end

  assign out_parallel = sym_q;
  assign debug_bias   = bias_q;

endmodule
